// File: rtl/oled_axil_pkg.sv
// Shared definitions for the OLED AXI4-Lite register bank: response codes
// and the write/read channel state encodings.
package oled_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/oled_axil_regbank.sv
// AXI4-Lite slave exposing NUM_RW control registers and NUM_RO status words,
// with independent write and read channel FSMs and per-register write strobes.
module oled_axil_regbank
  import oled_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 8,
  parameter int NUM_RO     = 4,
  parameter int ADDR_WIDTH = 8,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int RO_SLOTS  = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [STRB_W-1:0]              S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0]   ctrl_regs,
  input  logic [RO_SLOTS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_RW-1:0]              wr_pulse
);

  localparam int ADDR_LSB = $clog2(STRB_W);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_dw_check
    $error("oled_axil_regbank: DATA_WIDTH must be 32 or 64");
  end

  wr_state_t             wr_state_r;
  logic                  aw_ready_r;
  logic                  w_ready_r;
  logic                  aw_done_r;
  logic                  w_done_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]     wstrb_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic [NUM_RW-1:0]     wr_pulse_r;
  logic [DATA_WIDTH-1:0] ctrl_r [NUM_RW];

  rd_state_t             rd_state_r;
  logic                  ar_ready_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [STRB_W-1:0]     wr_strb_s;
  logic [31:0]           wr_idx_s;
  logic                  wr_is_rw_s;
  logic [31:0]           rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [1:0]            rd_resp_s;
  logic                  unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_in};

  // Write-side decode: a channel captured earlier takes precedence over the live bus.
  always_comb begin
    aw_hs_s    = S_AXI_AWVALID & aw_ready_r;
    w_hs_s     = S_AXI_WVALID & w_ready_r;
    commit_s   = (wr_state_r == WR_IDLE) && (aw_done_r || aw_hs_s) && (w_done_r || w_hs_s);
    wr_addr_s  = aw_done_r ? awaddr_r : S_AXI_AWADDR;
    wr_data_s  = w_done_r ? wdata_r : S_AXI_WDATA;
    wr_strb_s  = w_done_r ? wstrb_r : S_AXI_WSTRB;
    wr_idx_s   = 32'(wr_addr_s >> ADDR_LSB);
    wr_is_rw_s = (wr_idx_s < 32'(NUM_RW));
  end

  // Write channel FSM: independent AW/W capture, commit, then hold B until accepted.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_r <= WR_IDLE;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      awaddr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wstrb_r    <= {STRB_W{1'b0}};
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (commit_s) begin
            wr_state_r <= WR_RESP;
            bvalid_r   <= 1'b1;
            bresp_r    <= wr_is_rw_s ? RESP_OKAY : RESP_SLVERR;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
          end else begin
            aw_ready_r <= !(aw_done_r || aw_hs_s);
            w_ready_r  <= !(w_done_r || w_hs_s);
            if (aw_hs_s) begin
              aw_done_r <= 1'b1;
              awaddr_r  <= S_AXI_AWADDR;
            end
            if (w_hs_s) begin
              w_done_r <= 1'b1;
              wdata_r  <= S_AXI_WDATA;
              wstrb_r  <= S_AXI_WSTRB;
            end
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state_r <= WR_IDLE;
            bvalid_r   <= 1'b0;
            aw_ready_r <= 1'b1;
            w_ready_r  <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= WR_IDLE;
          bvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Control registers: byte-masked update on commit; strobe fires even with WSTRB=0.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_pulse_r <= {NUM_RW{1'b0}};
      for (int k = 0; k < NUM_RW; k++) begin
        ctrl_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        wr_pulse_r[k] <= commit_s && (wr_idx_s == 32'(k));
        for (int b = 0; b < STRB_W; b++) begin
          if (commit_s && (wr_idx_s == 32'(k)) && wr_strb_s[b]) begin
            ctrl_r[k][b*8 +: 8] <= wr_data_s[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux: pre-edge register contents, live status words, zero/SLVERR when unmapped.
  always_comb begin
    rd_idx_s  = 32'(S_AXI_ARADDR >> ADDR_LSB);
    rd_data_s = {DATA_WIDTH{1'b0}};
    rd_resp_s = RESP_SLVERR;
    for (int k = 0; k < NUM_RW; k++) begin
      rd_data_s = (rd_idx_s == 32'(k)) ? ctrl_r[k] : rd_data_s;
      rd_resp_s = (rd_idx_s == 32'(k)) ? RESP_OKAY : rd_resp_s;
    end
    for (int k = 0; k < NUM_RO; k++) begin
      rd_data_s = (rd_idx_s == 32'(NUM_RW + k)) ? status_in[k*DATA_WIDTH +: DATA_WIDTH] : rd_data_s;
      rd_resp_s = (rd_idx_s == 32'(NUM_RW + k)) ? RESP_OKAY : rd_resp_s;
    end
  end

  // Read channel FSM: one-cycle latency, R held until accepted.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_r <= RD_IDLE;
      ar_ready_r <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= {DATA_WIDTH{1'b0}};
      rresp_r    <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (S_AXI_ARVALID && ar_ready_r) begin
            rd_state_r <= RD_DATA;
            ar_ready_r <= 1'b0;
            rvalid_r   <= 1'b1;
            rdata_r    <= rd_data_s;
            rresp_r    <= rd_resp_s;
          end else begin
            ar_ready_r <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            rd_state_r <= RD_IDLE;
            ar_ready_r <= 1'b1;
            rvalid_r   <= 1'b0;
          end
        end
        default: begin
          rd_state_r <= RD_IDLE;
          rvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_ctrl
    assign ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_r[k];
  end

  assign S_AXI_AWREADY = aw_ready_r;
  assign S_AXI_WREADY  = w_ready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = ar_ready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign wr_pulse      = wr_pulse_r;

endmodule

// File: tb/tb_oled_axil_regbank.sv
// Randomised AXI4-Lite traffic against an array model of the register bank,
// plus directed scenarios with literal expectations.
module tb_oled_axil_regbank;

  localparam int DW  = 32;
  localparam int NRW = 8;
  localparam int NRO = 4;
  localparam int AW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [NRW*DW-1:0] ctrl_regs;
  logic [NRO*DW-1:0] status_in;
  logic [NRW-1:0]    wr_pulse;

  logic [DW-1:0]     mreg [NRW];
  logic [DW-1:0]     stat [NRO];
  logic [NRW-1:0]    exp_pulse;
  logic              chk_en;
  int                errors = 0;
  int                checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NRO; k++) begin : g_stat
    assign status_in[k*DW +: DW] = stat[k];
  end

  oled_axil_regbank #(.DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO), .ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  task automatic check(input string name, input logic [NRW*DW-1:0] act, input logic [NRW*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NRW*DW-1:0] model_ctrl();
    logic [NRW*DW-1:0] v;
    for (int k = 0; k < NRW; k++) v[k*DW +: DW] = mreg[k];
    return v;
  endfunction

  function automatic logic [DW-1:0] model_read(input int idx);
    if (idx < NRW) return mreg[idx];
    else if (idx < NRW + NRO) return stat[idx - NRW];
    else return 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input int idx, input int limit);
    return (idx < limit) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input int idx, input logic [DW-1:0] data, input logic [3:0] strb);
    if (idx < NRW) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mreg[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_pulse = 8'b1 << idx;
    end else begin
      exp_pulse = 8'b0;
    end
  endtask

  // Cycle-by-cycle comparison of the register outputs and strobes against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("ctrl_regs", ctrl_regs, model_ctrl());
      check("wr_pulse", {248'b0, wr_pulse}, {248'b0, exp_pulse});
    end
  end

  // lead>0: W leads AW by lead cycles; lead<0: AW leads; 0: same cycle.
  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int lead, input int bdly);
    int idx;
    logic [1:0] eresp;
    idx   = int'(addr >> 2);
    eresp = model_resp(idx, NRW);
    if (lead > 0) begin
      wdata = data; wstrb = strb; wvalid = 1'b1;
      @(posedge clk); #1; wvalid = 1'b0;
      check("wready_drop", {255'b0, wready}, 256'd0);
      for (int i = 1; i < lead; i++) begin @(posedge clk); #1; end
      awaddr = addr; awvalid = 1'b1;
    end else if (lead < 0) begin
      awaddr = addr; awvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0;
      check("awready_drop", {255'b0, awready}, 256'd0);
      for (int i = 1; i < -lead; i++) begin @(posedge clk); #1; end
      wdata = data; wstrb = strb; wvalid = 1'b1;
    end else begin
      awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(idx, data, strb);
    check("bvalid_set", {255'b0, bvalid}, 256'd1);
    check("bresp", {254'b0, bresp}, {254'b0, eresp});
    for (int i = 0; i < bdly; i++) begin
      @(posedge clk); #1; exp_pulse = 8'b0;
      check("bvalid_hold", {255'b0, bvalid}, 256'd1);
      check("bresp_hold", {254'b0, bresp}, {254'b0, eresp});
    end
    bready = 1'b1;
    @(posedge clk); #1; exp_pulse = 8'b0; bready = 1'b0;
    check("bvalid_clr", {255'b0, bvalid}, 256'd0);
    check("wr_readies", {254'b0, awready, wready}, 256'd3);
  endtask

  task automatic rd(input logic [7:0] addr, input int rdly, output logic [31:0] d, output logic [1:0] r);
    int idx;
    logic [31:0] ed;
    logic [1:0] er;
    idx = int'(addr >> 2);
    ed  = model_read(idx);
    er  = model_resp(idx, NRW + NRO);
    araddr = addr; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    check("rvalid_set", {255'b0, rvalid}, 256'd1);
    check("arready_low", {255'b0, arready}, 256'd0);
    check("rdata", {224'b0, rdata}, {224'b0, ed});
    check("rresp", {254'b0, rresp}, {254'b0, er});
    d = rdata; r = rresp;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", {255'b0, rvalid}, 256'd1);
      check("rdata_hold", {224'b0, rdata}, {224'b0, ed});
    end
    rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    check("rvalid_clr", {255'b0, rvalid}, 256'd0);
  endtask

  // Write and read launched on the same edge; the read must see the old value.
  task automatic wr_rd(input logic [7:0] addr, input logic [31:0] data, output logic [31:0] d);
    int idx;
    logic [31:0] ed;
    idx = int'(addr >> 2);
    ed  = model_read(idx);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = 4'hF; wvalid = 1'b1;
    araddr = addr; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(idx, data, 4'hF);
    check("wr_rd_bvalid", {255'b0, bvalid}, 256'd1);
    check("wr_rd_rvalid", {255'b0, rvalid}, 256'd1);
    check("wr_rd_rdata", {224'b0, rdata}, {224'b0, ed});
    d = rdata;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1; exp_pulse = 8'b0; bready = 1'b0; rready = 1'b0;
    check("wr_rd_done", {254'b0, bvalid, rvalid}, 256'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          op;
    logic [7:0]  a;

    rst_n = 1'b0; chk_en = 1'b0; exp_pulse = 8'b0;
    awaddr = 8'h0; awprot = 3'b0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 8'h0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;
    for (int k = 0; k < NRW; k++) mreg[k] = 32'h0;
    for (int k = 0; k < NRO; k++) stat[k] = 32'h0;

    #22;
    check("reset_outputs", {208'b0, awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, wr_pulse}, 256'd0);
    check("reset_ctrl", ctrl_regs, 256'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("readies_after_reset", {253'b0, awready, wready, arready}, 256'd7);
    chk_en = 1'b1;

    // Byte-strobed write over reset value.
    wr(8'h00, 32'hAABBCCDD, 4'b0101, 0, 0);
    rd(8'h00, 0, d, r);
    check("lit_strb_read", {224'b0, d}, {224'b0, 32'h00BB00DD});

    // Back-to-back full writes then readback.
    for (int i = 0; i < 4; i++) wr(8'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i * 4), 0, d, r);
      check("lit_readback", {222'b0, r, d}, {222'b0, 2'b00, 32'(i + 1)});
    end

    // W three cycles ahead of AW, slow BREADY.
    wr(8'h04, 32'hCAFE0004, 4'hF, 3, 5);
    rd(8'h04, 2, d, r);
    check("lit_w_first", {224'b0, d}, {224'b0, 32'hCAFE0004});

    // Status, RO write rejection, unmapped read.
    stat[0] = 32'h12345678;
    rd(8'h20, 0, d, r);
    check("lit_status", {222'b0, r, d}, {222'b0, 2'b00, 32'h12345678});
    wr(8'h20, 32'hFFFFFFFF, 4'hF, 0, 1);
    rd(8'h20, 0, d, r);
    check("lit_status_kept", {224'b0, d}, {224'b0, 32'h12345678});
    rd(8'h40, 1, d, r);
    check("lit_unmapped", {222'b0, r, d}, {222'b0, 2'b10, 32'h0});

    // Same-edge read/write hazard.
    wr(8'h08, 32'h5, 4'hF, 0, 0);
    wr_rd(8'h08, 32'h9, d);
    check("lit_old_value", {224'b0, d}, {224'b0, 32'h5});
    rd(8'h08, 0, d, r);
    check("lit_new_value", {224'b0, d}, {224'b0, 32'h9});

    // Randomised mix of traffic and status changes.
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 255));
      if (op == 0) begin
        rd(a, int'($urandom_range(0, 3)), d, r);
      end else if (op == 1) begin
        wr(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)));
      end else if (op == 2) begin
        wr_rd(8'($urandom_range(0, NRW * 4 - 1)), $urandom, d);
      end else begin
        for (int k = 0; k < NRO; k++) stat[k] = $urandom;
        @(posedge clk); #1;
      end
    end

    // Reset while a write response is pending.
    awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(3, 32'hDEADBEEF, 4'hF);
    check("pre_reset_bvalid", {255'b0, bvalid}, 256'd1);
    #2;
    rst_n = 1'b0;
    exp_pulse = 8'b0;
    for (int k = 0; k < NRW; k++) mreg[k] = 32'h0;
    #1;
    check("async_reset_outputs", {208'b0, awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, wr_pulse}, 256'd0);
    check("async_reset_ctrl", ctrl_regs, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("readies_after_reset2", {253'b0, awready, wready, arready}, 256'd7);
    for (int i = 0; i < NRW; i++) begin
      rd(8'(i * 4), 0, d, r);
      check("lit_zero_after_reset", {222'b0, r, d}, 256'd0);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
